// File: rtl/load_store_unit.sv
// Load/store unit for a 32-bit RISC-V style core: formats byte/half/word accesses
// onto a word-addressed memory handshake and reports faults.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [1:0]            fault_code,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [CW-1:0]         count_reg;
  logic [DATA_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [3:0]            be_reg;
  logic                  we_reg;
  logic [2:0]            funct3_reg;
  logic [1:0]            code_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  logic                  accept;
  logic                  illegal;
  logic                  misaligned;
  logic [1:0]            code_calc;
  logic [3:0]            be_calc;
  logic [DATA_WIDTH-1:0] wdata_calc;
  logic [DATA_WIDTH-1:0] rdata_shifted;
  logic [DATA_WIDTH-1:0] load_fmt;
  logic                  timeout_hit;

  assign accept = start && (MemRead ^ MemWrite);

  // Stores accept only the three signed encodings; loads also accept the unsigned ones.
  always_comb begin
    illegal = 1'b1;
    if (MemWrite) begin
      case (Funct3)
        3'b000, 3'b001, 3'b010: illegal = 1'b0;
        default:                illegal = 1'b1;
      endcase
    end else begin
      case (Funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
        default:                                illegal = 1'b1;
      endcase
    end
  end

  assign misaligned = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                      ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));

  assign code_calc = illegal ? 2'b10 : (misaligned ? 2'b01 : 2'b00);

  always_comb begin
    case (Funct3[1:0])
      2'b00:   be_calc = 4'b0001 << ALUResult[1:0];
      2'b01:   be_calc = ALUResult[1] ? 4'b1100 : 4'b0011;
      default: be_calc = 4'b1111;
    endcase
  end

  // Each byte lane picks its source byte according to access size.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_calc[8*gi +: 8] = (Funct3[1:0] == 2'b00) ? WriteData[7:0] :
                                   (Funct3[1:0] == 2'b01) ? WriteData[8*(gi%2) +: 8] :
                                                            WriteData[8*gi +: 8];
  end

  assign rdata_shifted = mem_rdata >> {addr_reg[1:0], 3'b000};

  always_comb begin
    case (funct3_reg)
      3'b000:  load_fmt = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_fmt = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_fmt = {24'd0, rdata_shifted[7:0]};
      3'b101:  load_fmt = {16'd0, rdata_shifted[15:0]};
      default: load_fmt = mem_rdata;
    endcase
  end

  assign timeout_hit = (count_reg == CW'(TIMEOUT - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = (code_calc != 2'b00) ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_next = S_DONE;
        end else if (timeout_hit) begin
          state_next = S_ERR;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      count_reg  <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      be_reg     <= '0;
      we_reg     <= 1'b0;
      funct3_reg <= '0;
      code_reg   <= '0;
      rdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            addr_reg   <= ALUResult;
            wdata_reg  <= wdata_calc;
            be_reg     <= be_calc;
            we_reg     <= MemWrite;
            funct3_reg <= Funct3;
            code_reg   <= code_calc;
            count_reg  <= '0;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            if (!we_reg) begin
              rdata_reg <= load_fmt;
            end
          end else if (timeout_hit) begin
            code_reg <= 2'b11;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_reg != S_IDLE);
  assign done       = (state_reg == S_DONE) || (state_reg == S_ERR);
  assign fault      = (state_reg == S_ERR);
  assign fault_code = (state_reg == S_ERR) ? code_reg : 2'b00;
  assign ReadData   = rdata_reg;

  // Memory-side outputs are quiet whenever no request is outstanding.
  assign mem_req   = (state_reg == S_REQ);
  assign mem_we    = mem_req && we_reg;
  assign mem_addr  = mem_req ? {addr_reg[DATA_WIDTH-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? be_reg : 4'b0000;
  assign mem_wdata = mem_req ? wdata_reg : '0;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of the data path and address.
REQ-002 The block SHALL have parameter TIMEOUT, default 16: maximum number of REQ-state cycles to wait for mem_ack.
REQ-003 The block SHALL have the following ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request pulse, sampled in IDLE only.
- MemRead  in  1  load request qualifier.
- MemWrite  in  1  store request qualifier.
- Funct3  in  3  access size and sign, RISC-V encoding.
- ALUResult  in  32  effective byte address from the ALU.
- WriteData  in  32  store data, right-aligned in the low bits.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- fault  out  1  qualifies done; the access failed.
- fault_code  out  2  01 misaligned, 10 illegal Funct3, 11 timeout.
- ReadData  out  32  formatted load result.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store.
- mem_addr  out  32  word address; bits [1:0] are always 00.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read word.
- mem_ack  in  1  memory completion.

Function
REQ-004 The FSM SHALL have four states: IDLE, REQ, DONE, ERR.
REQ-005 IDLE transition rule: on start=1 with exactly one of MemRead/MemWrite high, the block SHALL latch ALUResult, WriteData, Funct3 and the direction.
- It then goes to ERR if the access is illegal or misaligned, otherwise to REQ.
- start with MemRead and MemWrite both high or both low SHALL be ignored.
REQ-006 Legal Funct3 values:
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: 000 SB, 001 SH, 010 SW.
- Any other value SHALL be illegal, giving fault_code=10.
REQ-007 A halfword access with addr[0]=1, or a word access with addr[1:0]!=00, SHALL be misaligned, giving fault_code=01.
- Funct3 legality SHALL be checked before alignment.
REQ-008 In REQ the block SHALL hold mem_req=1 with mem_we, mem_addr, mem_be and mem_wdata stable until mem_ack=1 is sampled.
REQ-009 In REQ, mem_ack=1 SHALL cause a transition to DONE; for loads, the formatted mem_rdata SHALL be registered into ReadData at that edge.
REQ-010 A REQ cycle counter SHALL increment each REQ cycle without mem_ack.
- On reaching TIMEOUT, the block SHALL go to ERR with fault_code=11.
- If mem_ack arrives in the same cycle the limit is reached, mem_ack wins.
REQ-011 DONE SHALL last one cycle with done=1 and fault=0, then return to IDLE.
REQ-012 ERR SHALL last one cycle with done=1, fault=1 and the latched fault_code, then return to IDLE.
- ERR SHALL never assert mem_req.
REQ-013 Byte enables SHALL follow the access size:
- Byte access: mem_be = 0001 shifted left by addr[1:0].
- Halfword access: mem_be = 0011 if addr[1]=0, else 1100.
- Word access: mem_be = 1111.
- Loads SHALL drive the same mem_be as stores of the same size.
REQ-014 Store data SHALL be replicated across lanes:
- SB: WriteData[7:0] in all four bytes.
- SH: WriteData[15:0] in both halves.
- SW: WriteData unchanged.
REQ-015 Load formatting SHALL extract the addressed lane.
- LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend; LW SHALL pass the word unchanged.
REQ-016 ReadData SHALL change only on a successful load; stores and faults SHALL leave it unchanged.
REQ-017 mem_ack outside REQ SHALL be ignored, and start while busy SHALL be ignored.
REQ-018 Minimum latency: start in cycle 0 gives mem_req in cycle 1; mem_ack in cycle 1 gives done in cycle 2.
- A fault detected at start SHALL give done=1, fault=1 in cycle 1.
REQ-019 When mem_req=0, the outputs mem_we, mem_be and mem_wdata SHALL be 0.

Reset
REQ-020 reset=1 SHALL force IDLE, clear the counter, and drive every output to 0 (including ReadData and fault_code) at the next edge.
REQ-021 reset during REQ SHALL abort the access: mem_req=0 from the following cycle, with no done pulse.
REQ-022 reset SHALL take priority over start and mem_ack in the same cycle.

Verification
REQ-023 LB at addr 0x1003, mem_rdata=0x80112233, ack in first REQ cycle -> mem_addr=0x1000, mem_be=1000, done at cycle 2, ReadData=0xFFFFFF80.
REQ-024 SH at addr 0x2002, WriteData=0x0000BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEFBEEF, ReadData unchanged.
REQ-025 LW at 0x3001 -> no mem_req, done=1, fault=1, fault_code=01 in cycle 1; Funct3=011 load -> fault_code=10.
REQ-026 LHU at 0x4000, mem_ack never asserted, TIMEOUT=16 -> mem_req high for 16 cycles, then done=1, fault_code=11.
REQ-027 reset asserted in the third REQ cycle -> mem_req=0 and busy=0 next cycle, no done; a new LBU (mem_rdata=0x000000F0) -> ReadData=0x000000F0.
REQ-028 start with MemRead=MemWrite=1, and start while busy -> ignored; no state change, no extra mem_req.
